arc4_encrypt: RTL and testbench

//  ARC4 PRGA encryptor: writer-side counterpart of the ct-memory consumer. It takes a

---
 rtl/arc4_encrypt.sv | 182 ++++++++++++++++++
 tb/tb_arc4_encrypt.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt.sv
// ARC4 PRGA encryptor.
// Reads a length-prefixed plaintext from pt memory. Draws keystream bytes from an S memory
// that has already been key-scheduled, swapping S entries as it goes. Writes the
// length-prefixed ciphertext to ct memory.
// All memories are synchronous with one cycle of read latency. The *_WAIT states exist to
// cover that latency, and each address is held steady until its data has been consumed.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en_i         start request, sampled only while rdy_o=1
//   rdy_o        1 = idle, able to accept en_i
//   s_addr_o     S memory address
//   s_rddata_i   S memory read data
//   s_wrdata_o   S memory write data
//   s_wren_o     S memory write enable
//   pt_addr_o    plaintext memory address
//   pt_rddata_i  plaintext memory read data
//   ct_addr_o    ciphertext memory address
//   ct_wrdata_o  ciphertext memory write data
//   ct_wren_o    ciphertext memory write enable
module arc4_encrypt #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic          rdy_o,
  output logic [DW-1:0] s_addr_o,
  input  logic [DW-1:0] s_rddata_i,
  output logic [DW-1:0] s_wrdata_o,
  output logic          s_wren_o,
  output logic [DW-1:0] pt_addr_o,
  input  logic [DW-1:0] pt_rddata_i,
  output logic [DW-1:0] ct_addr_o,
  output logic [DW-1:0] ct_wrdata_o,
  output logic          ct_wren_o
);

  typedef enum logic [3:0] {
    StIdle,
    StLenRd,
    StLenWait,
    StLenWr,
    StIRd,
    StIWait,
    StJRd,
    StJWait,
    StSwapI,
    StSwapJ,
    StPadRd,
    StPadWait,
    StCtWr
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] i_q, i_d;
  logic [DW-1:0] j_q, j_d;
  logic [DW-1:0] k_q, k_d;
  logic [DW-1:0] len_q, len_d;
  logic [DW-1:0] si_q, si_d;
  logic [DW-1:0] sj_q, sj_d;
  logic [DW-1:0] pad_idx;

  // The pre-swap si+sj equals the post-swap S[i]+S[j], so the pad index needs no re-read.
  assign pad_idx = si_q + sj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    rdy_o       = 1'b0;
    s_addr_o    = '0;
    s_wrdata_o  = '0;
    s_wren_o    = 1'b0;
    pt_addr_o   = '0;
    ct_addr_o   = '0;
    ct_wrdata_o = '0;
    ct_wren_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        rdy_o = 1'b1;
        if (en_i) state_d = StLenRd;
      end
      // pt_addr_o stays at 0 through the length fetch.
      StLenRd:   state_d = StLenWait;
      StLenWait: state_d = StLenWr;
      StLenWr: begin
        ct_wren_o   = 1'b1;
        ct_wrdata_o = pt_rddata_i;
        len_d       = pt_rddata_i;
        i_d         = '0;
        j_d         = '0;
        k_d         = DW'(1);
        state_d     = (pt_rddata_i == '0) ? StIdle : StIRd;
      end
      StIRd: begin
        i_d      = i_q + DW'(1);
        s_addr_o = i_q + DW'(1);
        state_d  = StIWait;
      end
      StIWait: begin
        s_addr_o = i_q;
        state_d  = StJRd;
      end
      // s_rddata_i holds S[i] here, because i stayed on the bus through I_WAIT.
      StJRd: begin
        si_d     = s_rddata_i;
        j_d      = j_q + s_rddata_i;
        s_addr_o = j_q + s_rddata_i;
        state_d  = StJWait;
      end
      StJWait: begin
        s_addr_o = j_q;
        state_d  = StSwapI;
      end
      StSwapI: begin
        sj_d       = s_rddata_i;
        s_addr_o   = i_q;
        s_wrdata_o = s_rddata_i;
        s_wren_o   = 1'b1;
        state_d    = StSwapJ;
      end
      StSwapJ: begin
        s_addr_o   = j_q;
        s_wrdata_o = si_q;
        s_wren_o   = 1'b1;
        state_d    = StPadRd;
      end
      StPadRd: begin
        s_addr_o  = pad_idx;
        pt_addr_o = k_q;
        state_d   = StPadWait;
      end
      StPadWait: begin
        s_addr_o  = pad_idx;
        pt_addr_o = k_q;
        state_d   = StCtWr;
      end
      StCtWr: begin
        s_addr_o    = pad_idx;
        pt_addr_o   = k_q;
        ct_addr_o   = k_q;
        ct_wrdata_o = s_rddata_i ^ pt_rddata_i;
        ct_wren_o   = 1'b1;
        if (k_q == len_q) begin
          state_d = StIdle;
        end else begin
          k_d     = k_q + DW'(1);
          state_d = StIRd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt.
// Behavioural S, pt and ct memories have one cycle of read latency. A plain-arithmetic ARC4
// PRGA model checks the ciphertext and the final S contents.
module tb_arc4_encrypt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr, pt_rddata;
  logic [7:0] ct_addr, ct_wrdata;
  logic       ct_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] m_s    [256];
  logic [7:0] m_pt   [256];
  logic [7:0] m_ct   [256];
  logic [7:0] saved  [256];

  int vectors = 0;
  int miscompares = 0;
  int lo_cnt = 0, sw_cnt = 0, cw_cnt = 0, acc_cnt = 0;

  always #5 clk = ~clk;

  arc4_encrypt #(.DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .rdy_o      (rdy),
    .s_addr_o   (s_addr),
    .s_rddata_i (s_rddata),
    .s_wrdata_o (s_wrdata),
    .s_wren_o   (s_wren),
    .pt_addr_o  (pt_addr),
    .pt_rddata_i(pt_rddata),
    .ct_addr_o  (ct_addr),
    .ct_wrdata_o(ct_wrdata),
    .ct_wren_o  (ct_wren)
  );

  // Synchronous memories: q is the old contents at the address sampled on the edge.
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (s_wren) s_mem[s_addr] = s_wrdata;
    if (ct_wren) ct_mem[ct_addr] = ct_wrdata;
  end

  // Free-running event counters; tests read differences.
  always @(posedge clk) begin
    if (!rdy) lo_cnt++;
    if (s_wren) sw_cnt++;
    if (ct_wren) cw_cnt++;
    if (rdy && en && rst_n) acc_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
  endtask

  task automatic load_random_perm();
    logic [7:0] t;
    int r;
    load_identity();
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      t = s_mem[x]; s_mem[x] = s_mem[r]; s_mem[r] = t;
    end
  endtask

  task automatic load_ksa(input logic [23:0] key);
    logic [7:0] kb [3];
    logic [7:0] j, t;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    load_identity();
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      j = j + s_mem[x] + kb[x % 3];
      t = s_mem[x]; s_mem[x] = s_mem[j]; s_mem[j] = t;
    end
  endtask

  task automatic clear_ct();
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'hAA;
  endtask

  task automatic random_pt(input int len);
    pt_mem[0] = 8'(len);
    for (int x = 1; x < 256; x++) pt_mem[x] = 8'($urandom);
  endtask

  // Copies the memories into the model and computes the expected ct and final S.
  task automatic model_run();
    logic [7:0] i, j, t, idx;
    int len;
    for (int x = 0; x < 256; x++) begin
      m_s[x] = s_mem[x];
      m_pt[x] = pt_mem[x];
      m_ct[x] = 8'hAA;
    end
    len = int'(m_pt[0]);
    m_ct[0] = m_pt[0];
    i = 8'd0; j = 8'd0;
    for (int k = 1; k <= len; k++) begin
      i = i + 8'd1;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      idx = m_s[i] + m_s[j];
      m_ct[k] = m_pt[k] ^ m_s[idx];
    end
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy_return"}, 32'(rdy), 32'd1);
  endtask

  task automatic run_dut(input string tag);
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    wait_rdy(tag);
  endtask

  task automatic check_result(input string tag);
    int len, sdiff;
    len = int'(m_pt[0]);
    for (int k = 0; k <= len; k++) begin
      check($sformatf("%s_ct[%0d]", tag, k), 32'(ct_mem[k]), 32'(m_ct[k]));
    end
    check({tag, "_ct_past_end"}, 32'(ct_mem[(len + 1) % 256]), (len == 255) ? 32'(m_ct[0]) : 32'hAA);
    sdiff = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) sdiff++;
    check({tag, "_s_diffs"}, 32'(sdiff), 32'd0);
  endtask

  task automatic set_pt_fixed();
    pt_mem[0] = 8'h03; pt_mem[1] = 8'h41; pt_mem[2] = 8'h42; pt_mem[3] = 8'h43;
  endtask

  initial begin
    int lo0, sw0, cw0, ac0, len, period, exp_acc;
    rst_n = 1'b0;
    en = 1'b0;
    load_identity();
    clear_ct();
    for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;

    // Reset state
    #12;
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_s_wren", 32'(s_wren), 32'd0);
    check("rst_ct_wren", 32'(ct_wren), 32'd0);
    check("rst_addrs", {s_addr, pt_addr, ct_addr, 8'h00}, 32'd0);
    check("rst_wrdata", {16'h0, s_wrdata, ct_wrdata}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Identity S, fixed 3-byte message, with write-enable audit
    load_identity(); clear_ct(); set_pt_fixed(); model_run();
    lo0 = lo_cnt; sw0 = sw_cnt; cw0 = cw_cnt;
    run_dut("t1");
    check_result("t1");
    check("t1_ct1_const", 32'(ct_mem[1]), 32'h43);
    check("t1_ct2_const", 32'(ct_mem[2]), 32'h47);
    check("t1_ct3_const", 32'(ct_mem[3]), 32'h44);
    check("t1_s235", {8'h0, s_mem[2], s_mem[3], s_mem[5]}, 32'h030502);
    check("t1_rdy_low_cycles", 32'(lo_cnt - lo0), 32'd30);
    check("t1_s_wren_pulses", 32'(sw_cnt - sw0), 32'd6);
    check("t1_ct_wren_pulses", 32'(cw_cnt - cw0), 32'd4);

    // Zero-length message
    load_identity(); clear_ct(); pt_mem[0] = 8'h00; model_run();
    lo0 = lo_cnt; sw0 = sw_cnt; cw0 = cw_cnt;
    run_dut("t2");
    check_result("t2");
    check("t2_rdy_low_cycles", 32'(lo_cnt - lo0), 32'd3);
    check("t2_s_wren_pulses", 32'(sw_cnt - sw0), 32'd0);
    check("t2_ct_wren_pulses", 32'(cw_cnt - cw0), 32'd1);

    // Randomised S permutations and lengths
    for (int r = 0; r < 4; r++) begin
      len = int'($urandom_range(40, 1));
      load_random_perm(); clear_ct(); random_pt(len); model_run();
      lo0 = lo_cnt;
      run_dut($sformatf("rnd%0d", r));
      check_result($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_latency", r), 32'(lo_cnt - lo0), 32'(3 + 9 * len));
    end

    // Round trip: ksa(00033C), encrypt 255 bytes, re-schedule, decrypt
    load_ksa(24'h00033C); clear_ct(); random_pt(255); model_run();
    for (int x = 0; x < 256; x++) saved[x] = pt_mem[x];
    run_dut("t3enc");
    check_result("t3enc");
    load_ksa(24'h00033C);
    for (int x = 0; x < 256; x++) pt_mem[x] = ct_mem[x];
    clear_ct();
    run_dut("t3dec");
    for (int x = 0; x < 256; x++) begin
      check($sformatf("t3_roundtrip[%0d]", x), 32'(ct_mem[x]), 32'(saved[x]));
    end

    // en held high with a mid-run re-pulse: one run per rdy period
    load_identity(); clear_ct(); random_pt(2);
    period = 3 + 9 * 2 + 1;
    exp_acc = (50 - 1) / period + 1;
    ac0 = acc_cnt; sw0 = sw_cnt; cw0 = cw_cnt;
    @(negedge clk) en = 1'b1;
    for (int it = 1; it <= 50; it++) begin
      @(negedge clk);
      if (it == 5) en = 1'b0;
      if (it == 6) en = 1'b1;
    end
    en = 1'b0;
    wait_rdy("t4");
    check("t4_accepts", 32'(acc_cnt - ac0), 32'(exp_acc));
    check("t4_ct_wren_pulses", 32'(cw_cnt - cw0), 32'(exp_acc * 3));
    check("t4_s_wren_pulses", 32'(sw_cnt - sw0), 32'(exp_acc * 4));

    // Reset during byte 2 SWAP_I, then a clean rerun
    load_identity(); clear_ct(); set_pt_fixed();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    repeat (16) @(negedge clk);
    check("t5_in_swap_i", {28'h0, 1'b0, rdy, s_wren, ct_wren}, 32'b0010);
    rst_n = 1'b0;
    #1;
    check("t5_rst_s_wren", 32'(s_wren), 32'd0);
    check("t5_rst_ct_wren", 32'(ct_wren), 32'd0);
    check("t5_rst_rdy", 32'(rdy), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    load_identity(); clear_ct(); model_run();
    run_dut("t5");
    check_result("t5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
